// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback slice: segment patterns (a at bit 6, g at bit 0),
// decoded codes and the capture FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [2:0] CODE_E   = 3'b100;
    localparam logic [2:0] CODE_INV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from a sampled 7-segment pattern back to the display code.
// Blank is reported separately so the caller can skip the capture entirely.
module seg7_pattern_decode (
    input  logic [6:0] pattern,
    output logic [2:0] code,
    output logic       err,
    output logic       inv,
    output logic       blank
);
    import seg7_pkg::*;

    always_comb begin
        code  = CODE_INV;
        err   = 1'b0;
        inv   = 1'b0;
        blank = 1'b0;
        case (pattern)
            SEG_0:     code = 3'd0;
            SEG_1:     code = 3'd1;
            SEG_2:     code = 3'd2;
            SEG_3:     code = 3'd3;
            SEG_E: begin
                code = CODE_E;
                err  = 1'b1;
            end
            SEG_BLANK: begin
                code  = 3'd0;
                blank = 1'b1;
            end
            default:   inv = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Reads back a multiplexed 7-segment bus: debounces each digit's pattern and stores its decoded code.
// Define SEG7_CAP_ACTIVE_LOW_EN for common-anode boards (segments and digit_sel active-low).
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [6:0]                                       segments,
    input  logic [NUM_DIGITS-1:0]                            digit_sel,
    output logic [3*NUM_DIGITS-1:0]                          digit_val,
    output logic [NUM_DIGITS-1:0]                            digit_err,
    output logic [NUM_DIGITS-1:0]                            digit_inv,
    output logic                                             upd_valid,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx,
    output logic [2:0]                                       upd_code
);
    import seg7_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]            seg_in, seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0] sel_in, sel_p0, sel_p1;
    state_e                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  capture, same, onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic [2:0]            dec_code;
    logic                  dec_err, dec_inv, dec_blank;

    // Inversion sits ahead of the sample register so a reset sample of 0 always means "inactive".
`ifdef SEG7_CAP_ACTIVE_LOW_EN
    assign seg_in = ~segments;
    assign sel_in = ~digit_sel;
`else
    assign seg_in = segments;
    assign sel_in = digit_sel;
`endif

    // Stage p0: input sample; stage p1: previous sample for the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0 <= '0;
            sel_p0 <= '0;
            seg_p1 <= '0;
            sel_p1 <= '0;
        end else begin
            seg_p0 <= seg_in;
            sel_p0 <= sel_in;
            seg_p1 <= seg_p0;
            sel_p1 <= sel_p0;
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_p0),
        .code    (dec_code),
        .err     (dec_err),
        .inv     (dec_inv),
        .blank   (dec_blank)
    );

    assign same   = (seg_p0 == seg_p1) && (sel_p0 == sel_p1);
    assign onehot = $onehot(sel_p0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_p0[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (!onehot) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_W'(1);
                end
                ST_SETTLE: begin
                    if (!same) begin
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == CNT_MAX) begin
                            capture   = !dec_blank;
                            state_nxt = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!same) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stage p2: FSM state, digit register file and update pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            digit_val <= '0;
            digit_err <= '0;
            digit_inv <= '0;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_code  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            upd_valid <= capture;
            if (capture) begin
                upd_idx  <= sel_idx;
                upd_code <= dec_code;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel_p0[i]) begin
                    digit_val[3*i +: 3] <= dec_code;
                    digit_err[i]        <= dec_err;
                    digit_inv[i]        <= dec_inv;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed table-driven bench for seg7_capture (NUM_DIGITS=4, STABLE_CYCLES=4),
// plus hand-written reset sequences; honours SEG7_CAP_ACTIVE_LOW_EN when driving.
module tb_seg7_capture;
    import seg7_pkg::*;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    segments;
    logic [ND-1:0] digit_sel;
    logic [3*ND-1:0] digit_val;
    logic [ND-1:0] digit_err;
    logic [ND-1:0] digit_inv;
    logic          upd_valid;
    logic [1:0]    upd_idx;
    logic [2:0]    upd_code;

    int checks   = 0;
    int failures = 0;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .segments  (segments),
        .digit_sel (digit_sel),
        .digit_val (digit_val),
        .digit_err (digit_err),
        .digit_inv (digit_inv),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_code  (upd_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        int         hold;
        int         pulses;
        int         idx;
        int         code;
        int         chk;
        int         val;
        int         err;
        int         inv;
    } vec_t;

    vec_t vt[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg);
`ifdef SEG7_CAP_ACTIVE_LOW_EN
        digit_sel = ~sel;
        segments  = ~seg;
`else
        digit_sel = sel;
        segments  = seg;
`endif
    endtask

    task automatic run(input int n, output int pulses, output int last_idx, output int last_code);
        pulses    = 0;
        last_idx  = -1;
        last_code = -1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (upd_valid === 1'b1) begin
                pulses++;
                last_idx  = int'(upd_idx);
                last_code = int'(upd_code);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_val"},   digit_val, 0);
        check({tag, "_err"},   digit_err, 0);
        check({tag, "_inv"},   digit_inv, 0);
        check({tag, "_valid"}, upd_valid, 0);
        check({tag, "_idx"},   upd_idx,   0);
        check({tag, "_code"},  upd_code,  0);
    endtask

    initial begin
        int p, li, lc;

        //        sel      seg        hold pulses idx code chk val err inv
        vt[0]  = '{4'b0001, SEG_2,     10, 1, 0, 2,  0, 2, 0, 0};
        vt[1]  = '{4'b0100, SEG_E,      6, 1, 2, 4,  2, 4, 1, 0};
        vt[2]  = '{4'b0100, SEG_1,      6, 1, 2, 1,  2, 1, 0, 0};
        vt[3]  = '{4'b0001, SEG_0,      3, 0, 0, 0,  0, 2, 0, 0};
        vt[4]  = '{4'b0001, SEG_3,      6, 1, 0, 3,  0, 3, 0, 0};
        vt[5]  = '{4'b0011, SEG_0,      2, 0, 0, 0, -1, 0, 0, 0};
        vt[6]  = '{4'b0001, SEG_1,      5, 1, 0, 1,  0, 1, 0, 0};
        vt[7]  = '{4'b0011, SEG_1,      2, 0, 0, 0, -1, 0, 0, 0};
        vt[8]  = '{4'b0010, SEG_2,      5, 1, 1, 2,  1, 2, 0, 0};
        vt[9]  = '{4'b0011, SEG_2,      2, 0, 0, 0, -1, 0, 0, 0};
        vt[10] = '{4'b0100, SEG_3,      5, 1, 2, 3,  2, 3, 0, 0};
        vt[11] = '{4'b0011, SEG_3,      2, 0, 0, 0, -1, 0, 0, 0};
        vt[12] = '{4'b1000, 7'b1010101, 5, 1, 3, 7,  3, 7, 0, 1};
        vt[13] = '{4'b0100, SEG_BLANK,  6, 0, 0, 0,  2, 3, 0, 0};
        vt[14] = '{4'b1000, SEG_E,      5, 1, 3, 4,  3, 4, 1, 0};
        vt[15] = '{4'b0001, SEG_0,      5, 1, 0, 0,  0, 0, 0, 0};
        vt[16] = '{4'b0010, SEG_1,      5, 1, 1, 1,  1, 1, 0, 0};
        vt[17] = '{4'b0100, SEG_2,      5, 1, 2, 2,  2, 2, 0, 0};
        vt[18] = '{4'b1000, SEG_3,      5, 1, 3, 3,  3, 3, 0, 0};
        vt[19] = '{4'b0000, SEG_3,      2, 0, 0, 0, -1, 0, 0, 0};
        vt[20] = '{4'b1000, SEG_3,      5, 1, 3, 3,  3, 3, 0, 0};
        vt[21] = '{4'b0001, SEG_2,      3, 0, 0, 0,  0, 0, 0, 0};
        vt[22] = '{4'b0000, SEG_2,      2, 0, 0, 0, -1, 0, 0, 0};

        rst_n = 1'b0;
        drive('0, SEG_BLANK);
        #1;
        check_all_zero("reset_start");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("after_release");

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].sel, vt[i].seg);
            run(vt[i].hold, p, li, lc);
            check($sformatf("v%0d_pulses", i), p, vt[i].pulses);
            if (vt[i].pulses == 1) begin
                check($sformatf("v%0d_idx", i),  li, vt[i].idx);
                check($sformatf("v%0d_code", i), lc, vt[i].code);
            end
            if (vt[i].chk >= 0) begin
                check($sformatf("v%0d_val", i), digit_val[3*vt[i].chk +: 3], vt[i].val);
                check($sformatf("v%0d_err", i), digit_err[vt[i].chk], vt[i].err);
                check($sformatf("v%0d_inv", i), digit_inv[vt[i].chk], vt[i].inv);
            end
        end

        // Reset in the middle of a stability window
        drive(4'b0001, SEG_1);
        run(3, p, li, lc);
        check("mid_settle_pulses", p, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        run(2, p, li, lc);
        check("held_reset_pulses", p, 0);
        rst_n = 1'b1;
        run(SC, p, li, lc);
        check("post_reset_early_pulses", p, 0);
        run(3, p, li, lc);
        check("post_reset_pulses", p, 1);
        check("post_reset_idx", li, 0);
        check("post_reset_code", lc, 1);
        check("post_reset_val0", digit_val[2:0], 1);
        check("post_reset_val_others", digit_val[11:3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
